// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder with valid/ready start and done handshakes
//
// Computes {cout,sum} = a + b + cin one bit per clock, LSB first, through a
// single full-adder cell and one carry flop. An operand set is accepted on
// start_valid & start_ready; the result appears WIDTH cycles later and is
// held with done_valid until the consumer asserts done_ready.
//
// Ports:
//   clk         - clock, all state changes on the rising edge
//   rst_n       - asynchronous active-low reset
//   start_valid - requester offers a, b, cin
//   start_ready - block is idle and will accept an operand set
//   a, b        - addends, sampled only on the accept edge
//   cin         - carry-in, sampled only on the accept edge
//   done_valid  - sum/cout hold a finished result
//   done_ready  - consumer takes the result
//   sum         - registered result
//   cout        - registered final carry
//   busy        - an operation is in progress or waiting to be taken
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // Counter must hold the value WIDTH so it never wraps mid-operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;

  logic accept;
  logic fa_s;
  logic fa_c;

  // Single full-adder cell working on the current LSBs.
  assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  assign accept = start_valid & start_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid)  state_nxt = RUN;
      RUN:     if (cnt == LAST)  state_nxt = DONE;
      DONE:    if (done_ready)   state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      DONE:    done_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shift registers, carry flop, result and counter.
  // sum_r/cout_r are only written during RUN, so they hold through DONE
  // and into IDLE until the next operation starts shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum_r <= {fa_s, sum_r[WIDTH-1:1]};
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (cnt == LAST) begin
        cout_r <= fa_c;
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
    check({tag, "_done_valid"},  64'(done_valid),  64'd0);
    check({tag, "_busy"},        64'(busy),        64'd0);
    check({tag, "_sum"},         64'(sum),         64'd0);
    check({tag, "_cout"},        64'(cout),        64'd0);
  endtask

  // Called at a falling edge while the block is idle. Offers one operand
  // set, scrambles the inputs during the operation, measures latency and
  // checks the result against plain integer addition.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic ocin, input int hold);
    logic [W:0] exp_full;
    int lat;
    exp_full = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, ocin};
    check("idle_ready", 64'(start_ready), 64'd1);
    a = oa; b = ob; cin = ocin; start_valid = 1'b1;
    done_ready = (hold == 0);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!done_valid && lat < 20) begin
      check("run_ready_low", 64'(start_ready), 64'd0);
      check("run_busy", 64'(busy), 64'd1);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(W));
    if (!done_valid) return;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 64'(done_valid), 64'd1);
      check("hold_ready_low", 64'(start_ready), 64'd0);
      check("hold_sum", 64'(sum), 64'(exp_full[W-1:0]));
      check("hold_cout", 64'(cout), 64'(exp_full[W]));
      start_valid = 1'($urandom);
      a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    check("sum", 64'(sum), 64'(exp_full[W-1:0]));
    check("cout", 64'(cout), 64'(exp_full[W]));
    check("done_busy", 64'(busy), 64'd1);
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("back_idle_ready", 64'(start_ready), 64'd1);
    check("back_idle_valid", 64'(done_valid), 64'd0);
    check("back_idle_busy", 64'(busy), 64'd0);
    check("idle_sum_held", 64'(sum), 64'(exp_full[W-1:0]));
    done_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; done_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_release");

    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h5A, 8'h3C, 1'b1, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 5);
    run_op(8'h00, 8'h00, 1'b0, 1);

    // Back-to-back with start_valid left high between operations.
    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Abort mid-RUN with an asynchronous reset.
    a = 8'hAA; b = 8'h55; cin = 1'b1; start_valid = 1'b1; done_ready = 1'b1;
    @(posedge clk);
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_valid", 64'(done_valid), 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_abort_no_valid", 64'(done_valid), 64'd0);
      check("post_abort_idle", 64'(start_ready), 64'd1);
    end
    run_op(8'h10, 8'h20, 1'b0, 0);

    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
